// File: rtl/if_id_skid_register.sv
`default_nettype none
//============================================================================
// Module   : if_id_skid_register
// Purpose  : Fetch/decode boundary register with a 1-entry skid slot and
//            flush. Optional StallCount output under IF_ID_STALL_COUNT_EN.
// Revision : 1.0 - initial release
//============================================================================
module if_id_skid_register #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = '0,
    parameter int                    PC_INCREMENT = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] InPC,
    input  logic [DATA_WIDTH-1:0] InInstruction,
    input  logic                  InValid,
    output logic                  FetchReady,
    input  logic                  Stall,
    input  logic                  Flush,
    output logic [DATA_WIDTH-1:0] OutPC,
    output logic [DATA_WIDTH-1:0] OutPCPlus4,
    output logic [DATA_WIDTH-1:0] OutInstruction,
    output logic                  OutValid
`ifdef IF_ID_STALL_COUNT_EN
    ,
    output logic [15:0]           StallCount
`endif
);

    localparam logic [DATA_WIDTH-1:0] c_pc_inc = DATA_WIDTH'(PC_INCREMENT);

    logic [DATA_WIDTH-1:0] r_main_pc, r_main_pc4, r_main_instr;
    logic                  r_main_valid;
    logic [DATA_WIDTH-1:0] r_skid_pc, r_skid_pc4, r_skid_instr;
    logic                  r_skid_valid;

    logic                  w_accept;
    logic                  w_main_advance;
    logic [DATA_WIDTH-1:0] w_in_pc4;

    // Ready depends only on registered state so the PC enable has no
    // combinational path from the hazard unit.
    assign FetchReady     = !r_skid_valid;
    assign w_accept       = InValid && FetchReady;
    assign w_main_advance = !Stall || !r_main_valid;
    assign w_in_pc4       = InPC + c_pc_inc;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_main_pc    <= '0;
            r_main_pc4   <= '0;
            r_main_instr <= NOP_INSTR;
            r_main_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_pc4   <= '0;
            r_skid_instr <= NOP_INSTR;
            r_skid_valid <= 1'b0;
        end else if (Flush) begin
            r_main_instr <= NOP_INSTR;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_advance) begin
            // The skid entry is always older than anything on the input.
            if (r_skid_valid) begin
                r_main_pc    <= r_skid_pc;
                r_main_pc4   <= r_skid_pc4;
                r_main_instr <= r_skid_instr;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main_pc    <= InPC;
                r_main_pc4   <= w_in_pc4;
                r_main_instr <= InInstruction;
                r_main_valid <= 1'b1;
            end else begin
                r_main_instr <= NOP_INSTR;
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_pc    <= InPC;
            r_skid_pc4   <= w_in_pc4;
            r_skid_instr <= InInstruction;
            r_skid_valid <= 1'b1;
        end
    end

    assign OutPC          = r_main_pc;
    assign OutPCPlus4     = r_main_pc4;
    assign OutInstruction = r_main_instr;
    assign OutValid       = r_main_valid;

`ifdef IF_ID_STALL_COUNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_stall_count <= '0;
        end else if (Stall && r_main_valid && !Flush && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign StallCount = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: doc/if_id_skid_register.md
Name: if_id_skid_register

Overview:
- Fetch/decode pipeline boundary directly downstream of the program counter.
- Captures the fetched (PC, instruction) pair and presents it to decode with a valid flag.
- Absorbs one in-flight fetch during a decode stall using a 1-entry skid slot.
- Drives FetchReady back to the PC's WriteEnable, and supports a flush on branch/jump redirect.

Parameters:
- DATA_WIDTH, 32, width of PC and instruction fields.
- NOP_INSTR, 32'h00000000, instruction value presented while OutValid=0.
- PC_INCREMENT, 4, value added to the captured PC to form OutPCPlus4.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- InPC  input  DATA_WIDTH  PC of the fetched instruction.
- InInstruction  input  DATA_WIDTH  instruction-memory read data for InPC.
- InValid  input  1  fetch presents a valid pair this cycle.
- FetchReady  output  1  block can accept a fetch this cycle; drives the PC WriteEnable.
- Stall  input  1  decode/hazard unit holds the current decode entry.
- Flush  input  1  discard all held and incoming entries (redirect).
- OutPC  output  DATA_WIDTH  PC of the decode entry.
- OutPCPlus4  output  DATA_WIDTH  OutPC + PC_INCREMENT, registered.
- OutInstruction  output  DATA_WIDTH  instruction of the decode entry; NOP_INSTR when invalid.
- OutValid  output  1  decode entry valid.

Behaviour:
- Interface: one clock, Clock; reset is synchronous and active-high, port name Reset.
- Storage: main slot (drives Out*) and skid slot; each slot holds PC, PC+4, instruction and a valid bit.
- Reset at the clock edge: both valid bits 0; OutPC=0, OutPCPlus4=0, OutInstruction=NOP_INSTR, OutValid=0.
  - FetchReady=1 in the first cycle after reset.
  - Reset overrides every other input.
- FetchReady = !skid_valid. This is combinational from registered state only; no path from Stall or InValid.
- Accept = InValid & FetchReady.
- Priority per edge: Reset > Flush > normal operation.
- Flush=1:
  - Both valid bits cleared; OutInstruction=NOP_INSTR next cycle.
  - An accepted input in the same cycle is discarded.
  - Stall is ignored.
- Normal operation, Stall=0 (main advances):
  - skid_valid=1: main <= skid; skid_valid <= 0. If Accept is also set, the input goes to skid (cannot occur, since FetchReady=0).
  - skid_valid=0, Accept: main <= input (latency 1 cycle, fetch to decode).
  - skid_valid=0, no Accept: main_valid <= 0; OutInstruction <= NOP_INSTR (bubble).
- Normal operation, Stall=1:
  - main_valid=1: main holds. An Accept loads skid; skid_valid=1 drops FetchReady the next cycle.
  - main_valid=0: main <= input on Accept. An invalid entry is never "stalled".
- Stall with both slots full: both hold; FetchReady=0, so no data is lost.
- Full pipeline with no stall: one entry per cycle, sustained throughput 1.
- PC+4 is computed at capture as InPC + PC_INCREMENT, modulo 2^DATA_WIDTH. 32'hFFFFFFFC wraps to 0.
- Field values of an invalid slot are don't-care, except OutInstruction, which must equal NOP_INSTR whenever OutValid=0.
- Ordering: entries leave in acceptance order. The skid entry is always older than any new input.

Optional Feature:
- Macro IF_ID_STALL_COUNT_EN.
- Defined:
  - Extra output StallCount [15:0].
  - Increments by 1 on each edge with Stall=1 & OutValid=1 & Flush=0.
  - Saturates at 16'hFFFF.
  - Cleared only by Reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then stream: InValid=1 with PC 0,4,8 on consecutive cycles and Stall=0.
  - OutPC 0,4,8 one cycle later each.
  - OutPCPlus4 4,8,12.
  - OutValid=1; FetchReady stays 1.
- Stall for 3 cycles while PC=8 is in main and PC=12 is offered:
  - 12 captured into skid; FetchReady=0 from the next cycle.
  - OutPC stays 8.
  - On release, OutPC 12, then the next fetch; no entry lost or duplicated.
- Flush while both slots are full and InValid=1 (PC=16):
  - Next cycle OutValid=0, OutInstruction=32'h00000000, FetchReady=1.
  - PC=16 never appears at the output.
- InValid=0 with Stall=0 after a valid entry:
  - Next cycle OutValid=0, OutInstruction=NOP_INSTR (bubble).
- Reset asserted mid-stall with skid full:
  - Next cycle all outputs at reset values and FetchReady=1.
  - Flush and Stall are ignored that cycle.
- With IF_ID_STALL_COUNT_EN: 5 stalled cycles with OutValid=1, plus 2 stalled cycles with OutValid=0 → StallCount=5.
  - Force the count to 16'hFFFF via a long stall; it stays at 16'hFFFF.
